// File: rtl/adc_ltc2308_ctrl.sv
// LTC2308 SPI conversion controller: CONVST pulse, 12-bit SCK frame, config word out / sample in.
// Latency: sample_valid in cycle CONV_CYCLES+2+24*SCK_HALF after accept (114 with defaults).
// Backpressure: none; start is ignored while busy and sample_valid is a single-cycle pulse.
module adc_ltc2308_ctrl #(
    parameter int CONV_CYCLES = 64,
    parameter int SCK_HALF    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [2:0]  channel,
    output logic        busy,
    output logic        sample_valid,
    output logic [11:0] sample_data,
    output logic [2:0]  sample_channel,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_GAP,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [9:0] CONV_LAST = 10'(CONV_CYCLES - 1);
    localparam logic [3:0] HALF_LAST = 4'(SCK_HALF - 1);

    state_t      state_q, state_d;
    logic [9:0]  conv_cnt_q;
    logic [3:0]  half_cnt_q;
    logic [3:0]  bit_cnt_q;
    logic [5:0]  cfg_q;
    logic [11:0] data_q, data_d;
    logic [2:0]  cur_ch_q, prev_ch_q;
    logic        primed_q;
    logic        accept, half_end, sck_fall, capture;

    assign half_end = (half_cnt_q == HALF_LAST);

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        sck_fall = 1'b0;
        capture  = 1'b0;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (start || (continuous && primed_q)) begin
                    accept  = 1'b1;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (conv_cnt_q == CONV_LAST) state_d = S_GAP;
            end
            S_GAP:   state_d = S_SHIFT;
            S_SHIFT: begin
                sck_fall = half_end && adc_sck;
                // SDO is taken in the first high cycle of each SCK period
                capture  = adc_sck && (half_cnt_q == 4'd0);
                if (sck_fall && (bit_cnt_q == 4'd11)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (capture) data_d = {data_q[10:0], adc_sdo};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy           <= 1'b0;
            sample_valid   <= 1'b0;
            sample_data    <= 12'd0;
            sample_channel <= 3'd0;
            adc_convst     <= 1'b0;
            adc_sck        <= 1'b0;
            adc_sdi        <= 1'b0;
            conv_cnt_q     <= 10'd0;
            half_cnt_q     <= 4'd0;
            bit_cnt_q      <= 4'd0;
            cfg_q          <= 6'd0;
            data_q         <= 12'd0;
            cur_ch_q       <= 3'd0;
            prev_ch_q      <= 3'd0;
            primed_q       <= 1'b0;
        end else begin
            adc_convst   <= (state_d == S_CONV);
            busy         <= (state_d != S_IDLE);
            sample_valid <= 1'b0;
            data_q       <= data_d;

            if (accept) begin
                cur_ch_q   <= channel;
                // S/D, O/S, S1, S0, UNI, SLP
                cfg_q      <= {1'b1, channel[0], channel[2], channel[1], 1'b1, 1'b0};
                conv_cnt_q <= 10'd0;
            end

            if (state_q == S_CONV) conv_cnt_q <= conv_cnt_q + 10'd1;

            if (state_q == S_GAP) begin
                adc_sdi    <= cfg_q[5];
                cfg_q      <= {cfg_q[4:0], 1'b0};
                half_cnt_q <= 4'd0;
                bit_cnt_q  <= 4'd0;
            end

            if (state_q == S_SHIFT) begin
                if (half_end) begin
                    half_cnt_q <= 4'd0;
                    adc_sck    <= !adc_sck;
                end else begin
                    half_cnt_q <= half_cnt_q + 4'd1;
                end
                // zeros shift in behind the config word, so SDI drops to 0 after bit 6
                if (sck_fall) begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    adc_sdi   <= cfg_q[5];
                    cfg_q     <= {cfg_q[4:0], 1'b0};
                end
            end

            if ((state_q == S_SHIFT) && (state_d == S_DONE) && primed_q) begin
                sample_valid   <= 1'b1;
                sample_data    <= data_d;
                sample_channel <= prev_ch_q;
            end

            if (state_q == S_DONE) begin
                prev_ch_q <= cur_ch_q;
                primed_q  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Directed bench for adc_ltc2308_ctrl with a behavioural LTC2308 SDO model.
module tb_adc_ltc2308_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [2:0]  channel = 3'd0;
    logic        busy, sample_valid;
    logic [11:0] sample_data;
    logic [2:0]  sample_channel;
    logic        adc_convst, adc_sck, adc_sdi, adc_sdo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [11:0] sdo_word = 12'd0;
    logic [11:0] sdo_sh   = 12'd0;
    logic        sck_prev = 1'b0;

    adc_ltc2308_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .continuous     (continuous),
        .channel        (channel),
        .busy           (busy),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .sample_channel (sample_channel),
        .adc_convst     (adc_convst),
        .adc_sck        (adc_sck),
        .adc_sdi        (adc_sdi),
        .adc_sdo        (adc_sdo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: result word loaded during CONVST, next bit presented after each SCK fall
    assign adc_sdo = sdo_sh[11];
    always @(negedge clk) begin
        if (adc_convst)             sdo_sh <= sdo_word;
        else if (sck_prev && !adc_sck) sdo_sh <= {sdo_sh[10:0], 1'b0};
        sck_prev <= adc_sck;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (first CONV cycle)
    task automatic do_start(input logic [2:0] ch);
        channel = ch;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({busy, sample_valid, sample_data, sample_channel, adc_convst, adc_sck, adc_sdi} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 00000",
                     {busy, sample_valid, sample_data, sample_channel, adc_convst, adc_sck, adc_sdi});
        end
        reset_n = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({busy, adc_convst} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_start: busy/convst got %b expected 00", {busy, adc_convst});
        end
    endtask

    task automatic test_priming();
        logic seen;
        sdo_word = 12'h123;
        do_start(3'd3);
        n_tests++;
        if ({busy, adc_convst} !== 2'b11) begin
            n_fail++;
            $display("FAIL accept_cycle1: busy/convst got %b expected 11", {busy, adc_convst});
        end
        seen = 1'b0;
        for (int c = 2; c <= 116; c++) begin
            tick();
            if (sample_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL priming_no_valid: got %b expected 0", seen);
        end

        sdo_word = 12'hA5C;
        do_start(3'd5);
        for (int c = 2; c <= 115; c++) begin
            tick();
            if (c == 113) begin
                n_tests++;
                if (sample_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL valid_early: cycle 113 got %b expected 0", sample_valid);
                end
            end
            if (c == 114) begin
                n_tests++;
                if ({sample_valid, busy, sample_data, sample_channel} !== {1'b1, 1'b1, 12'hA5C, 3'd3}) begin
                    n_fail++;
                    $display("FAIL first_sample: valid/busy/data/ch got %b %b %h %0d expected 1 1 a5c 3",
                             sample_valid, busy, sample_data, sample_channel);
                end
            end
            if (c == 115) begin
                n_tests++;
                if ({sample_valid, busy, sample_data} !== {1'b0, 1'b0, 12'hA5C}) begin
                    n_fail++;
                    $display("FAIL after_done: valid/busy/data got %b %b %h expected 0 0 a5c",
                             sample_valid, busy, sample_data);
                end
            end
        end
    endtask

    task automatic test_timing();
        int hi, first, last, nr, sck_bad, per_bad;
        int rise_c[12];
        logic [11:0] sdi_bits, exp_sdi;
        logic sck_last;
        hi = 0; first = -1; last = -1; nr = 0; sck_bad = 0; per_bad = 0;
        sdi_bits = 12'd0; sck_last = 1'b0;
        exp_sdi = 12'b1011_1000_0000;
        sdo_word = 12'h5A3;
        do_start(3'd6);
        for (int c = 1; c <= 115; c++) begin
            if (c > 1) tick();
            if (adc_convst) begin
                hi++;
                if (first < 0) first = c;
                last = c;
            end
            if (adc_sck && !sck_last) begin
                if (nr < 12) begin
                    rise_c[nr] = c;
                    sdi_bits[11-nr] = adc_sdi;
                end
                nr++;
            end
            if ((c <= 65 || c == 115) && adc_sck) sck_bad++;
            sck_last = adc_sck;
            if (c == 114) begin
                n_tests++;
                if ({sample_valid, sample_data, sample_channel} !== {1'b1, 12'h5A3, 3'd5}) begin
                    n_fail++;
                    $display("FAIL timing_sample: valid/data/ch got %b %h %0d expected 1 5a3 5",
                             sample_valid, sample_data, sample_channel);
                end
            end
        end
        n_tests++;
        if (hi !== 64 || first !== 1 || last !== 64) begin
            n_fail++;
            $display("FAIL convst_width: high=%0d first=%0d last=%0d expected 64 1 64", hi, first, last);
        end
        n_tests++;
        if (nr !== 12) begin
            n_fail++;
            $display("FAIL sck_count: got %0d expected 12", nr);
        end
        if (nr >= 12) begin
            for (int k = 1; k < 12; k++) if (rise_c[k] - rise_c[k-1] != 4) per_bad++;
            n_tests++;
            if (rise_c[0] !== 68 || per_bad !== 0) begin
                n_fail++;
                $display("FAIL sck_period: first rise %0d bad periods %0d expected 68 0", rise_c[0], per_bad);
            end
        end
        n_tests++;
        if (sck_bad !== 0) begin
            n_fail++;
            $display("FAIL sck_idle_low: high cycles %0d expected 0", sck_bad);
        end
        n_tests++;
        if (sdi_bits !== exp_sdi) begin
            n_fail++;
            $display("FAIL sdi_ch6: got %b expected %b", sdi_bits, exp_sdi);
        end
    endtask

    task automatic test_continuous();
        logic [11:0] words [9];
        int prev_req, last_cyc, k;
        logic got;
        words = '{12'h000, 12'hFFF, 12'h123, 12'h800, 12'h7FF, 12'h001, 12'hAAA, 12'h555, 12'hC3C};
        prev_req = 6;
        last_cyc = 0;
        channel = 3'd0;
        sdo_word = words[0];
        continuous = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            got = 1'b0;
            k = 0;
            while (!got && k < 200) begin
                tick();
                k++;
                if (sample_valid) got = 1'b1;
            end
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("FAIL cont_timeout: conversion %0d no valid within 200 cycles", i);
            end else begin
                if (sample_channel !== 3'(prev_req) || sample_data !== words[i]) begin
                    n_fail++;
                    $display("FAIL cont_sample%0d: ch/data got %0d %h expected %0d %h",
                             i, sample_channel, sample_data, prev_req, words[i]);
                end
                if (i > 0) begin
                    n_tests++;
                    if (cyc - last_cyc != 115) begin
                        n_fail++;
                        $display("FAIL cont_spacing%0d: got %0d expected 115", i, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
            end
            prev_req = i % 8;
            channel = 3'((i + 1) % 8);
            if (i < 8) sdo_word = words[i+1];
            else       continuous = 1'b0;
        end
        repeat (5) tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_stop: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int rises, nr;
        logic cv_last, sck_last;
        logic [11:0] sdi_bits, exp_sdi;
        rises = 0; nr = 0; cv_last = 1'b0; sck_last = 1'b0; sdi_bits = 12'd0;
        exp_sdi = 12'b1001_1000_0000;
        sdo_word = 12'h3C5;
        channel = 3'd2;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 125; c++) begin
            if (c > 1) tick();
            if (c == 10)  channel = 3'd7;
            if (c == 100) start = 1'b0;
            if (adc_convst && !cv_last) rises++;
            cv_last = adc_convst;
            if (adc_sck && !sck_last) begin
                if (nr < 12) sdi_bits[11-nr] = adc_sdi;
                nr++;
            end
            sck_last = adc_sck;
            if (c == 114) begin
                n_tests++;
                if ({sample_valid, sample_data, sample_channel} !== {1'b1, 12'h3C5, 3'd0}) begin
                    n_fail++;
                    $display("FAIL held_sample: valid/data/ch got %b %h %0d expected 1 3c5 0",
                             sample_valid, sample_data, sample_channel);
                end
            end
            if (c == 120) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL held_no_queue: busy got %b expected 0", busy);
                end
            end
        end
        n_tests++;
        if (rises !== 1) begin
            n_fail++;
            $display("FAIL held_accepts: convst pulses %0d expected 1", rises);
        end
        n_tests++;
        if (sdi_bits !== exp_sdi) begin
            n_fail++;
            $display("FAIL sdi_ch2_locked: got %b expected %b", sdi_bits, exp_sdi);
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        sdo_word = 12'h111;
        do_start(3'd4);
        for (int c = 2; c <= 80; c++) tick();
        n_tests++;
        if ({adc_sck, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_pre: sck/busy got %b expected 11", {adc_sck, busy});
        end
        #3 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({adc_convst, adc_sck, busy, sample_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_async: convst/sck/busy/valid got %b expected 0000",
                     {adc_convst, adc_sck, busy, sample_valid});
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        do_start(3'd1);
        seen = 1'b0;
        for (int c = 2; c <= 116; c++) begin
            tick();
            if (sample_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reprime: valid got %b expected 0", seen);
        end
        sdo_word = 12'h9E7;
        do_start(3'd2);
        for (int c = 2; c <= 114; c++) tick();
        n_tests++;
        if ({sample_valid, sample_data, sample_channel} !== {1'b1, 12'h9E7, 3'd1}) begin
            n_fail++;
            $display("FAIL abort_resume: valid/data/ch got %b %h %0d expected 1 9e7 1",
                     sample_valid, sample_data, sample_channel);
        end
    endtask

    initial begin
        test_reset();
        test_priming();
        test_timing();
        test_continuous();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
